// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB widths and bundle type, used by the arbiter, the ROB and the reservation stations.
package cdb_arbiter_pkg;

  localparam int ROB_ENTRIES = 32;
  localparam int ROB_IDX_W   = $clog2(ROB_ENTRIES);
  localparam int DATA_W      = 64;
  localparam int REG_W       = 5;
  localparam int CDB_NUM_FU  = 4;

  typedef struct packed {
    logic                 valid;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [DATA_W-1:0]    value;
    logic [REG_W-1:0]     dest_reg;
  } cdb_t;

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr_i (wrapping) is granted.
module rr_arbiter #(
  parameter int NUM_FU = 4,
  parameter int PTR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic [NUM_FU-1:0] req_i,
  input  logic [PTR_W-1:0]  ptr_i,
  output logic [NUM_FU-1:0] gnt_o
);

  logic found;
  int   idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = (int'(ptr_i) + k) % NUM_FU;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Per-FU one-entry holding buffers feeding a round-robin arbiter that drives a registered CDB.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = CDB_NUM_FU
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic [NUM_FU-1:0]           fu_valid_i,
  input  logic [NUM_FU*ROB_IDX_W-1:0] fu_rob_idx_i,
  input  logic [NUM_FU*DATA_W-1:0]    fu_value_i,
  input  logic [NUM_FU*REG_W-1:0]     fu_dest_reg_i,
  output logic [NUM_FU-1:0]           fu_ready_o,
  output logic                        cdb_valid_o,
  output logic [ROB_IDX_W-1:0]        cdb_rob_idx_o,
  output logic [DATA_W-1:0]           cdb_value_o,
  output logic [REG_W-1:0]            cdb_dest_reg_o
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_FU - 1);

  logic [NUM_FU-1:0]    hold_valid;
  logic [ROB_IDX_W-1:0] hold_tag [NUM_FU];
  logic [DATA_W-1:0]    hold_val [NUM_FU];
  logic [REG_W-1:0]     hold_dst [NUM_FU];
  logic [NUM_FU-1:0]    grant;
  logic                 any_grant;

  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]     win_idx;
  cdb_t                 win;
  cdb_t                 cdb_q, cdb_d;

  // A granted buffer drains at the same edge, so it may accept a refill now.
  assign fu_ready_o = {NUM_FU{rst_ni & ~flush_i}} & (~hold_valid | grant);

  for (genvar g = 0; g < NUM_FU; g++) begin : g_buf
    logic                 valid_q;
    logic [ROB_IDX_W-1:0] tag_q;
    logic [DATA_W-1:0]    val_q;
    logic [REG_W-1:0]     dst_q;
    logic                 load;

    assign load = fu_valid_i[g] & fu_ready_o[g];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        valid_q <= 1'b0;
        tag_q   <= '0;
        val_q   <= '0;
        dst_q   <= '0;
      end else if (flush_i) begin
        valid_q <= 1'b0;
      end else if (load) begin
        valid_q <= 1'b1;
        tag_q   <= fu_rob_idx_i[g*ROB_IDX_W +: ROB_IDX_W];
        val_q   <= fu_value_i[g*DATA_W +: DATA_W];
        dst_q   <= fu_dest_reg_i[g*REG_W +: REG_W];
      end else if (grant[g]) begin
        valid_q <= 1'b0;
      end
    end

    assign hold_valid[g] = valid_q;
    assign hold_tag[g]   = tag_q;
    assign hold_val[g]   = val_q;
    assign hold_dst[g]   = dst_q;
  end

  rr_arbiter #(
    .NUM_FU (NUM_FU),
    .PTR_W  (PTR_W)
  ) u_rr_arbiter (
    .req_i  (hold_valid),
    .ptr_i  (rr_ptr_q),
    .gnt_o  (grant)
  );

  assign any_grant = |grant;

  always_comb begin
    win_idx = '0;
    win     = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (grant[i]) begin
        win_idx      = PTR_W'(i);
        win.valid    = 1'b1;
        win.rob_idx  = hold_tag[i];
        win.value    = hold_val[i];
        win.dest_reg = hold_dst[i];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    cdb_d    = cdb_q;
    if (flush_i) begin
      rr_ptr_d    = '0;
      cdb_d.valid = 1'b0;
    end else if (any_grant) begin
      rr_ptr_d = (win_idx == LAST_PTR) ? '0 : win_idx + 1'b1;
      cdb_d    = win;
    end else begin
      cdb_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      cdb_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cdb_q    <= cdb_d;
    end
  end

  assign cdb_valid_o    = cdb_q.valid;
  assign cdb_rob_idx_o  = cdb_q.rob_idx;
  assign cdb_value_o    = cdb_q.value;
  assign cdb_dest_reg_o = cdb_q.dest_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single result, contention, fairness, streaming, flush, async reset.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int TW = ROB_IDX_W;
  localparam int DW = DATA_W;
  localparam int RW = REG_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic [N-1:0]      fu_valid = '0;
  logic [N*TW-1:0]   fu_rob_idx = '0;
  logic [N*DW-1:0]   fu_value = '0;
  logic [N*RW-1:0]   fu_dest_reg = '0;
  logic [N-1:0]      fu_ready;
  logic              cdb_valid;
  logic [TW-1:0]     cdb_rob_idx;
  logic [DW-1:0]     cdb_value;
  logic [RW-1:0]     cdb_dest_reg;

  int n_cmp = 0;
  int n_bad = 0;

  cdb_arbiter #(.NUM_FU(N)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_i        (flush),
    .fu_valid_i     (fu_valid),
    .fu_rob_idx_i   (fu_rob_idx),
    .fu_value_i     (fu_value),
    .fu_dest_reg_i  (fu_dest_reg),
    .fu_ready_o     (fu_ready),
    .cdb_valid_o    (cdb_valid),
    .cdb_rob_idx_o  (cdb_rob_idx),
    .cdb_value_o    (cdb_value),
    .cdb_dest_reg_o (cdb_dest_reg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fu(input int i, input logic v, input logic [TW-1:0] t,
                        input logic [DW-1:0] val, input logic [RW-1:0] d);
    fu_valid[i]              = v;
    fu_rob_idx[i*TW +: TW]   = t;
    fu_value[i*DW +: DW]     = val;
    fu_dest_reg[i*RW +: RW]  = d;
  endtask

  task automatic test_reset();
    fu_valid = '1;
    #2;
    n_cmp++; if (cdb_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", cdb_valid); end
    n_cmp++; if (cdb_rob_idx !== '0) begin n_bad++; $display("FAIL reset_tag: got %0d want 0", cdb_rob_idx); end
    n_cmp++; if (cdb_value !== '0) begin n_bad++; $display("FAIL reset_value: got %h want 0", cdb_value); end
    n_cmp++; if (cdb_dest_reg !== '0) begin n_bad++; $display("FAIL reset_dest: got %0d want 0", cdb_dest_reg); end
    n_cmp++; if (fu_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready: got %b want 0000", fu_ready); end
    fu_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (fu_ready !== 4'b1111) begin n_bad++; $display("FAIL release_ready: got %b want 1111", fu_ready); end
  endtask

  task automatic test_single();
    set_fu(0, 1'b1, 5'd5, 64'hDEAD, 5'd3);
    tick();
    fu_valid = '0;
    n_cmp++; if (cdb_valid !== 1'b0) begin n_bad++; $display("FAIL single_early: got %b want 0", cdb_valid); end
    tick();
    n_cmp++; if (cdb_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", cdb_valid); end
    n_cmp++; if (cdb_rob_idx !== 5'd5) begin n_bad++; $display("FAIL single_tag: got %0d want 5", cdb_rob_idx); end
    n_cmp++; if (cdb_value !== 64'hDEAD) begin n_bad++; $display("FAIL single_value: got %h want dead", cdb_value); end
    n_cmp++; if (cdb_dest_reg !== 5'd3) begin n_bad++; $display("FAIL single_dest: got %0d want 3", cdb_dest_reg); end
    tick();
    n_cmp++; if (cdb_valid !== 1'b0) begin n_bad++; $display("FAIL single_drop: got %b want 0", cdb_valid); end
    n_cmp++; if (cdb_rob_idx !== 5'd5) begin n_bad++; $display("FAIL single_hold_tag: got %0d want 5", cdb_rob_idx); end
  endtask

  task automatic test_contention();
    logic [N-1:0] exp_rdy [4];
    exp_rdy[0] = 4'b0011; exp_rdy[1] = 4'b0111; exp_rdy[2] = 4'b1111; exp_rdy[3] = 4'b1111;
    // rr_ptr is 1 after the single test; a flush returns it to 0
    flush = 1'b1;
    #1;
    n_cmp++; if (fu_ready !== 4'b0000) begin n_bad++; $display("FAIL cont_flush_ready: got %b want 0000", fu_ready); end
    tick();
    flush = 1'b0;
    for (int i = 0; i < N; i++) set_fu(i, 1'b1, TW'(i + 1), 64'(100 + i), RW'(i));
    tick();
    fu_valid = '0;
    #1;
    n_cmp++; if (fu_ready !== 4'b0001) begin n_bad++; $display("FAIL cont_ready_full: got %b want 0001", fu_ready); end
    for (int k = 0; k < N; k++) begin
      tick();
      n_cmp++; if (cdb_valid !== 1'b1) begin n_bad++; $display("FAIL cont_valid[%0d]: got %b want 1", k, cdb_valid); end
      n_cmp++; if (cdb_rob_idx !== TW'(k + 1)) begin n_bad++; $display("FAIL cont_tag[%0d]: got %0d want %0d", k, cdb_rob_idx, k + 1); end
      n_cmp++; if (fu_ready !== exp_rdy[k]) begin n_bad++; $display("FAIL cont_ready[%0d]: got %b want %b", k, fu_ready, exp_rdy[k]); end
    end
    tick();
    n_cmp++; if (cdb_valid !== 1'b0) begin n_bad++; $display("FAIL cont_idle: got %b want 0", cdb_valid); end
  endtask

  task automatic test_fairness();
    logic [TW-1:0] t0, t2, exp_tag;
    logic [RW-1:0] exp_dst;
    logic [N-1:0]  rdy;
    t0 = 5'd2;
    t2 = 5'd16;
    set_fu(0, 1'b1, t0, 64'(t0), 5'd0);
    set_fu(2, 1'b1, t2, 64'(t2), 5'd2);
    for (int e = 1; e <= 10; e++) begin
      rdy = fu_ready;
      tick();
      if (rdy[0]) t0 = t0 + 1'b1;
      if (rdy[2]) t2 = t2 + 1'b1;
      set_fu(0, 1'b1, t0, 64'(t0), 5'd0);
      set_fu(2, 1'b1, t2, 64'(t2), 5'd2);
      if (e >= 2) begin
        exp_tag = (e % 2 == 0) ? TW'(2 + (e - 2) / 2) : TW'(16 + (e - 3) / 2);
        exp_dst = (e % 2 == 0) ? 5'd0 : 5'd2;
        n_cmp++; if (cdb_valid !== 1'b1) begin n_bad++; $display("FAIL fair_valid[%0d]: got %b want 1", e, cdb_valid); end
        n_cmp++; if (cdb_rob_idx !== exp_tag) begin n_bad++; $display("FAIL fair_tag[%0d]: got %0d want %0d", e, cdb_rob_idx, exp_tag); end
        n_cmp++; if (cdb_dest_reg !== exp_dst) begin n_bad++; $display("FAIL fair_fu[%0d]: got %0d want %0d", e, cdb_dest_reg, exp_dst); end
      end
    end
    fu_valid = '0;
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      if (i < 8) set_fu(3, 1'b1, TW'(10 + i), 64'h1000 + 64'(i), 5'd7);
      else fu_valid = '0;
      #1;
      if (i < 8) begin
        n_cmp++; if (fu_ready[3] !== 1'b1) begin n_bad++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, fu_ready[3]); end
      end
      tick();
      if (i >= 1 && i <= 8) begin
        n_cmp++; if (cdb_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, cdb_valid); end
        n_cmp++; if (cdb_rob_idx !== TW'(9 + i)) begin n_bad++; $display("FAIL b2b_tag[%0d]: got %0d want %0d", i, cdb_rob_idx, 9 + i); end
        n_cmp++; if (cdb_value !== 64'h1000 + 64'(i - 1)) begin n_bad++; $display("FAIL b2b_value[%0d]: got %h want %h", i, cdb_value, 64'h1000 + 64'(i - 1)); end
      end else if (i == 9) begin
        n_cmp++; if (cdb_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_end: got %b want 0", cdb_valid); end
      end
    end
  endtask

  task automatic test_flush();
    set_fu(1, 1'b1, 5'd27, 64'd27, 5'd1);
    tick();
    fu_valid = '0;
    set_fu(0, 1'b1, 5'd25, 64'd25, 5'd0);
    set_fu(2, 1'b1, 5'd26, 64'd26, 5'd2);
    tick();
    fu_valid = '0;
    n_cmp++; if (cdb_rob_idx !== 5'd27 || cdb_valid !== 1'b1) begin n_bad++; $display("FAIL flush_pre: got %b/%0d want 1/27", cdb_valid, cdb_rob_idx); end
    // rr_ptr is now 2 with buffers 0 and 2 full
    flush = 1'b1;
    set_fu(0, 1'b1, 5'd25, 64'd25, 5'd0);
    #1;
    n_cmp++; if (fu_ready !== 4'b0000) begin n_bad++; $display("FAIL flush_ready: got %b want 0000", fu_ready); end
    n_cmp++; if (cdb_valid !== 1'b1) begin n_bad++; $display("FAIL flush_visible: got %b want 1", cdb_valid); end
    tick();
    flush = 1'b0;
    fu_valid = '0;
    n_cmp++; if (cdb_valid !== 1'b0) begin n_bad++; $display("FAIL flush_cdb: got %b want 0", cdb_valid); end
    set_fu(1, 1'b1, 5'd28, 64'd28, 5'd1);
    set_fu(3, 1'b1, 5'd29, 64'd29, 5'd3);
    tick();
    fu_valid = '0;
    n_cmp++; if (cdb_valid !== 1'b0) begin n_bad++; $display("FAIL flush_stale: got %b/%0d want 0", cdb_valid, cdb_rob_idx); end
    tick();
    n_cmp++; if (cdb_valid !== 1'b1 || cdb_rob_idx !== 5'd28) begin n_bad++; $display("FAIL flush_first: got %b/%0d want 1/28", cdb_valid, cdb_rob_idx); end
    tick();
    n_cmp++; if (cdb_valid !== 1'b1 || cdb_rob_idx !== 5'd29) begin n_bad++; $display("FAIL flush_second: got %b/%0d want 1/29", cdb_valid, cdb_rob_idx); end
    tick();
    n_cmp++; if (cdb_valid !== 1'b0) begin n_bad++; $display("FAIL flush_drain: got %b want 0", cdb_valid); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) set_fu(i, 1'b1, TW'(20 + i), 64'(20 + i), RW'(i));
    tick();
    fu_valid = '0;
    set_fu(3, 1'b1, 5'd23, 64'd23, 5'd3);
    tick();
    fu_valid = '0;
    n_cmp++; if (cdb_valid !== 1'b1 || cdb_rob_idx !== 5'd20) begin n_bad++; $display("FAIL rmid_pre: got %b/%0d want 1/20", cdb_valid, cdb_rob_idx); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (cdb_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid: got %b want 0", cdb_valid); end
    n_cmp++; if (cdb_rob_idx !== '0 || cdb_value !== '0 || cdb_dest_reg !== '0) begin n_bad++; $display("FAIL rmid_payload: got %0d/%h/%0d want 0/0/0", cdb_rob_idx, cdb_value, cdb_dest_reg); end
    n_cmp++; if (fu_ready !== 4'b0000) begin n_bad++; $display("FAIL rmid_ready: got %b want 0000", fu_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++; if (cdb_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_stale[%0d]: got %b/%0d want 0", c, cdb_valid, cdb_rob_idx); end
    end
    set_fu(2, 1'b1, 5'd9, 64'd9, 5'd2);
    tick();
    fu_valid = '0;
    tick();
    n_cmp++; if (cdb_valid !== 1'b1 || cdb_rob_idx !== 5'd9) begin n_bad++; $display("FAIL rmid_after: got %b/%0d want 1/9", cdb_valid, cdb_rob_idx); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Collects completed results from the functional units and broadcasts at most one per cycle on the common data bus (CDB). The ROB consumes the CDB to mark entries complete. Each FU gets a one-entry holding buffer with a valid/ready handshake, and the buffers are served in round-robin order. A branch-mispredict flush from the ROB squashes every in-flight result.

## Interface
- NUM_FU, 4, number of functional-unit result ports (≥2)
- ROB_IDX_W, 5, ROB tag width (32 ROB entries)
- DATA_W, 64, result value width
- REG_W, 5, architectural destination register index width

- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- flush  in  1  synchronous squash from the ROB
- fu_valid  in  NUM_FU  FU i presents a result
- fu_rob_idx  in  NUM_FU*ROB_IDX_W  ROB tag, FU i in bits [i*ROB_IDX_W +: ROB_IDX_W]
- fu_value  in  NUM_FU*DATA_W  result value, packed the same way
- fu_dest_reg  in  NUM_FU*REG_W  destination register, packed the same way
- fu_ready  out  NUM_FU  buffer i accepts this cycle
- cdb_valid  out  1  broadcast valid
- cdb_rob_idx  out  ROB_IDX_W  broadcast ROB tag
- cdb_value  out  DATA_W  broadcast value
- cdb_dest_reg  out  REG_W  broadcast destination register

## Operation
- **Holding buffers.** Per FU, hold_valid[i] plus payload.
  - Transfer when fu_valid[i] & fu_ready[i] at a rising edge.
  - FU payload must stay stable while fu_valid=1 and fu_ready=0.
- **fu_ready** is combinational: `fu_ready[i] = reset & ~flush & (~hold_valid[i] | grant[i])`. A granted buffer therefore refills in the same edge it drains.
- **Arbitration** (combinational) over hold_valid:
  - Search starts at rr_ptr and wraps modulo NUM_FU; the first valid buffer wins.
  - grant is one-hot or zero.
- **rr_ptr update.**
  - After a grant to i: rr_ptr ← (i+1) mod NUM_FU.
  - With no grant: rr_ptr is unchanged.
- **CDB output** is registered.
  - On a grant: cdb_* ← the winner's payload, cdb_valid ← 1, and hold_valid[winner] clears unless refilled the same edge.
  - With no grant: cdb_valid ← 0 and payload fields hold their previous values.
- **No backpressure.** The ROB always accepts the CDB.
- **Flush** (priority over everything except reset). At the edge where flush=1:
  - all hold_valid ← 0
  - cdb_valid ← 0
  - rr_ptr ← 0
  - FU handshakes are impossible because fu_ready=0.
- **Reset** (asynchronous, at any time, including mid-broadcast):
  - hold_valid ← 0, rr_ptr ← 0
  - cdb_valid ← 0, cdb_rob_idx ← 0, cdb_value ← 0, cdb_dest_reg ← 0
  - fu_ready = 0 while reset=0.

## Timing
- **Latency.** A result accepted at edge N appears on the CDB after edge N+1, if it wins arbitration there. With contention it waits at most NUM_FU−1 extra cycles.
- **Throughput.**
  - 1 result per cycle aggregate.
  - 1 per cycle from a single FU when uncontended (grant and refill happen in the same cycle).
- **Reset release.** fu_ready goes high in the first cycle reset=1 and flush=0. The first possible cdb_valid is two edges later.
- **Flush and CDB.** When flush coincides with a CDB broadcast already registered, that broadcast stays visible for its cycle. The ROB discards it.

## Structure
- **Shared header/package:**
  - ROB_ENTRIES=32 and derived ROB_IDX_W=5
  - DATA_W=64, REG_W=5
  - a CDB bundle definition (valid, rob_idx, value, dest_reg)
  - the ROB and the reservation stations share these.
- **Sub-module rr_arbiter** (NUM_FU parameter): inputs request vector and rr_ptr; output one-hot grant. Purely combinational. rr_ptr register stays in cdb_arbiter.
- Holding buffers: generate loop inside cdb_arbiter, no separate module.

## Test plan
- **Single result.** Reset, then FU0 presents tag 5 / value 0xDEAD / dest 3 for one cycle at edge 1 → cdb_valid=1, tag 5, value 0xDEAD, dest 3 after edge 2, and cdb_valid=0 after edge 3.
- **Contention.** rr_ptr=0, all 4 FUs valid at the same edge with tags 1,2,3,4 → CDB tags 1,2,3,4 on consecutive cycles. fu_ready[i] stays 0 on each full, ungranted buffer until it is granted.
- **Fairness.** FU0 held continuously valid with new tags each cycle, FU2 also continuously valid → CDB alternates FU0, FU2, FU0, FU2. Neither starves, and FU1/FU3 are never granted.
- **Back-to-back single FU.** FU3 valid every cycle with tags 10..17 and no other requests → fu_ready[3]=1 every cycle. Tags 10..17 appear on 8 consecutive cycles.
- **Flush.** Buffers 0 and 2 full, flush=1 for one cycle → fu_ready=0 during flush, cdb_valid=0 after the edge, and both results never appear. The next accepted FU1 result wins with rr_ptr=0.
- **Reset mid-operation.** reset=0 asynchronously while cdb_valid=1 and 3 buffers are full → cdb_* all zero immediately. After release, no stale tag is ever broadcast.
